sec_alarm_agg: RTL and testbench
================================

Name: sec_alarm_agg

Overview:
- Parametrised security alarm aggregator; successor to the fixed 3-source irq OR in the security subsystem.
- Per source: synchronises, debounces, latches and masks N alarm inputs (mesh, sensor, gluechain, future detectors).
- Drives one registered irq and a timed escalation output: if an alarm stays unserviced, escalation requests a chip reset.
- Configured through a simple word-addressed register port behind the subsystem APB bridge.

Parameters:
- SRCN, 8, number of alarm sources (1..32).
- DBW, 4, debounce counter width in bits.
- ESCW, 16, escalation timeout counter width in bits (1..31).

Ports:
- clk, input, 1, block clock.
- reset, input, 1, synchronous, active-high reset.
- src, input, SRCN, raw alarm inputs; may be asynchronous to clk.
- reg_sel, input, 1, register access strobe.
- reg_we, input, 1, 1 = write, 0 = read.
- reg_addr, input, 3, word address.
- reg_wdata, input, 32, write data.
- reg_rdata, output, 32, read data; registered.
- irq, output, 1, aggregated interrupt.
- esc, output, 1, escalation / reset request; sticky.
- esc_state, output, 2, FSM state, for debug and test.

Behaviour:
- Reset is synchronous and active-high.
- Reset values: all registers 0, irq=0, esc=0, reg_rdata=0, esc_state=IDLE(0), sync flops and debounce counters 0.
- Register map (bits above SRCN, DBW or ESCW read 0):
  - 0 EN[SRCN-1:0]: per-source enable.
  - 1 MODE[SRCN-1:0]: 0 = level, 1 = rising-edge.
  - 2 STATUS[SRCN-1:0]: sticky; write 1 to clear.
  - 3 ESC: [ESCW-1:0] timeout, [31] escalation enable.
  - 4 LOCK[0]: write 1 sets lock; only reset clears it.
  - 5 DBNC[DBW-1:0]: debounce count.
  - Addresses 6-7 read 0; writes to them are ignored.
- Write: takes effect the cycle after reg_sel & reg_we.
- Read: reg_rdata is valid the cycle after reg_sel & ~reg_we and holds until the next read.
- Lock: when LOCK=1, writes to EN, MODE, ESC and DBNC are ignored. STATUS W1C remains allowed.
- Synchroniser: 2-flop per source, giving s[i].
- Debounce, per source:
  - Counter resets to 0 when s[i]=0.
  - When s[i]=1, the counter increments and saturates at DBNC.
  - q[i]=1 when s[i]=1 and counter==DBNC; DBNC=0 means q=s.
- Latch:
  - Level mode: STATUS[i] is set on every cycle q[i]=1.
  - Edge mode: STATUS[i] is set on a q[i] 0→1 transition only.
  - Status is latched regardless of EN.
- Simultaneous set and W1C on the same bit: set wins, and the bit stays 1.
- irq is registered: irq(t+1) = |(STATUS & EN)(t).
- Latency: src edge → STATUS at 3+DBNC cycles (2 sync + 1 latch) → irq one cycle later.
- Escalation FSM:
  - IDLE(0) → ARMED(1) when irq=1 and ESC[31]=1. On entry, timer loads ESC timeout.
  - ARMED: timer decrements each cycle. irq=0 → IDLE. ESC[31] cleared (unlocked) → IDLE.
  - ARMED → FIRE(2) when timer==0 and irq=1; timeout 0 therefore fires one cycle after arming.
  - FIRE: esc=1; state and esc hold until reset. Clearing STATUS has no effect.
  - State 3 is unreachable; if entered, go to FIRE (fail-secure).
- Reset asserted mid-operation: everything returns to reset values on the next edge, including FIRE and LOCK.

Test Plan:
- EN=0x01, MODE=0, DBNC=0: pulse src[0] high for 1 cycle at t0 → STATUS=0x01 at t0+3, irq=1 at t0+4. W1C 0x01 → irq=0 two cycles later.
- DBNC=5: src[2] high for 5 cycles → no STATUS. Held high for 6+ cycles → STATUS[2] set at 3+5 cycles after the rising edge.
- MODE[1]=1, src[1] held high, W1C bit 1 after it latches → STATUS stays 0. MODE[1]=0 with the same stimulus → bit re-sets the cycle after the clear.
- ESC=0x8000_000A, EN=0x01, alarm on src[0] left uncleared → esc_state 0→1 one cycle after irq, esc=1 eleven cycles after arming. Second run clears STATUS at arm+5 → back to IDLE, esc stays 0.
- LOCK=1, then write EN=0 → EN read back unchanged. W1C on STATUS still works. After reset, LOCK=0.
- Same-cycle set and W1C on bit 3 → STATUS[3]=1. Reset asserted while in FIRE → esc=0, esc_state=0 on the next cycle.

Source files
------------

// File: rtl/sec_alarm_agg.sv
// Security alarm aggregator: per-source sync, debounce, latch and mask of SRCN alarm
// inputs into one registered irq, plus a timed escalation (chip reset request) FSM.
module sec_alarm_agg #(
    parameter int unsigned SRCN = 8,
    parameter int unsigned DBW  = 4,
    parameter int unsigned ESCW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SRCN-1:0] src,
    input  logic            reg_sel,
    input  logic            reg_we,
    input  logic [2:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic            irq,
    output logic            esc,
    output logic [1:0]      esc_state
);

    localparam int unsigned DW = 32;

    localparam logic [2:0] A_EN     = 3'd0;
    localparam logic [2:0] A_MODE   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_ESC    = 3'd3;
    localparam logic [2:0] A_LOCK   = 3'd4;
    localparam logic [2:0] A_DBNC   = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } esc_state_t;

    // Configuration and status registers
    logic [SRCN-1:0] en;
    logic [SRCN-1:0] mode;
    logic [SRCN-1:0] status;
    logic [ESCW-1:0] esc_tmo;
    logic            esc_en;
    logic            lock;
    logic [DBW-1:0]  dbnc;

    // Alarm datapath
    logic [SRCN-1:0] sync1;
    logic [SRCN-1:0] s;
    logic [DBW-1:0]  cnt [SRCN];
    logic [SRCN-1:0] q;
    logic [SRCN-1:0] q_prev;
    logic [SRCN-1:0] set_c;
    logic [SRCN-1:0] clr_c;

    // Escalation
    esc_state_t      state;
    esc_state_t      state_next;
    logic [ESCW-1:0] timer;
    logic [ESCW-1:0] timer_next;
    logic            esc_next;

    logic wr_c;
    logic rd_c;
    logic cfg_wr_c;
    logic unused_wdata;

    assign wr_c         = reg_sel & reg_we;
    assign rd_c         = reg_sel & ~reg_we;
    assign cfg_wr_c     = wr_c & ~lock;
    assign unused_wdata = ^reg_wdata;

    // Configuration writes; lock freezes everything but STATUS W1C
    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= '0;
            mode    <= '0;
            esc_tmo <= '0;
            esc_en  <= 1'b0;
            lock    <= 1'b0;
            dbnc    <= '0;
        end else begin
            if (cfg_wr_c && reg_addr == A_EN) begin
                en <= reg_wdata[SRCN-1:0];
            end
            if (cfg_wr_c && reg_addr == A_MODE) begin
                mode <= reg_wdata[SRCN-1:0];
            end
            if (cfg_wr_c && reg_addr == A_ESC) begin
                esc_tmo <= reg_wdata[ESCW-1:0];
                esc_en  <= reg_wdata[31];
            end
            if (cfg_wr_c && reg_addr == A_DBNC) begin
                dbnc <= reg_wdata[DBW-1:0];
            end
            if (wr_c && reg_addr == A_LOCK && reg_wdata[0]) begin
                lock <= 1'b1;
            end
        end
    end

    // Read port; data holds until the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_rdata <= '0;
        end else if (rd_c) begin
            case (reg_addr)
                A_EN:     reg_rdata <= DW'(en);
                A_MODE:   reg_rdata <= DW'(mode);
                A_STATUS: reg_rdata <= DW'(status);
                A_ESC:    reg_rdata <= DW'(esc_tmo) | {esc_en, 31'b0};
                A_LOCK:   reg_rdata <= DW'(lock);
                A_DBNC:   reg_rdata <= DW'(dbnc);
                default:  reg_rdata <= '0;
            endcase
        end
    end

    // Two-flop synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= src;
            s     <= sync1;
        end
    end

    // Debounce counters saturate at DBNC; a drop in DBNC clamps the count
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(SRCN); i++) begin
            if (reset || !s[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] < dbnc) begin
                cnt[i] <= cnt[i] + DBW'(1);
            end else begin
                cnt[i] <= dbnc;
            end
        end
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < int'(SRCN); i++) begin
            q[i] = s[i] && (cnt[i] == dbnc);
        end
    end

    // Level sources set every cycle q is high, edge sources only on q rising
    assign set_c = q & (~mode | ~q_prev);
    assign clr_c = (wr_c && reg_addr == A_STATUS) ? reg_wdata[SRCN-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_prev <= '0;
            status <= '0;
            irq    <= 1'b0;
        end else begin
            q_prev <= q;
            status <= (status & ~clr_c) | set_c;
            irq    <= |(status & en);
        end
    end

    // Escalation state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            esc   <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            esc   <= esc_next;
        end
    end

    // Escalation next-state; FIRE is terminal and the spare encoding fails into it
    always_comb begin
        state_next = state;
        timer_next = timer;
        esc_next   = esc;
        case (state)
            IDLE: begin
                if (irq && esc_en) begin
                    state_next = ARMED;
                    timer_next = esc_tmo;
                end
            end
            ARMED: begin
                if (!irq || !esc_en) begin
                    state_next = IDLE;
                end else if (timer == '0) begin
                    state_next = FIRE;
                end else begin
                    timer_next = timer - ESCW'(1);
                end
            end
            FIRE: begin
                state_next = FIRE;
            end
            default: begin
                state_next = FIRE;
            end
        endcase
        if (state_next == FIRE) begin
            esc_next = 1'b1;
        end
    end

    assign esc_state = state;

endmodule

// File: tb/tb_sec_alarm_agg.sv
// Directed self-checking bench for sec_alarm_agg (SRCN=8, DBW=4, ESCW=16).
module tb_sec_alarm_agg;

    logic        clk;
    logic        reset;
    logic [7:0]  src;
    logic        reg_sel;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        irq;
    logic        esc;
    logic [1:0]  esc_state;

    int n_checks;
    int n_fail;

    sec_alarm_agg #(.SRCN(8), .DBW(4), .ESCW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .reg_sel   (reg_sel),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq       (irq),
        .esc       (esc),
        .esc_state (esc_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_sel = 1'b0; reg_we = 1'b0; reg_wdata = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        reg_sel = 1'b1; reg_we = 1'b0; reg_addr = a;
        tick();
        reg_sel = 1'b0;
        d = reg_rdata;
    endtask

    task automatic pulse(input int idx);
        src[idx] = 1'b1;
        tick();
        src[idx] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        n_checks++; if (esc !== 1'b0) begin n_fail++; $display("FAIL reset_esc got %b want 0", esc); end
        n_checks++; if (esc_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", esc_state); end
        n_checks++; if (reg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", reg_rdata); end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d got %h want 0", a, d); end
        end
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_reg6 got %h want 0", d); end
    endtask

    task automatic test_level_basic();
        wr(3'd0, 32'h01);
        pulse(0);
        tick();
        reg_sel = 1'b1; reg_we = 1'b0; reg_addr = 3'd2;
        tick();
        n_checks++; if (reg_rdata !== 32'h0) begin n_fail++; $display("FAIL lat_status_t2 got %h want 0", reg_rdata); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL lat_irq_t3 got %b want 0", irq); end
        tick();
        reg_sel = 1'b0;
        n_checks++; if (reg_rdata !== 32'h1) begin n_fail++; $display("FAIL lat_status_t3 got %h want 1", reg_rdata); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL lat_irq_t4 got %b want 1", irq); end
        wr(3'd2, 32'h01);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_c1 got %b want 1", irq); end
        tick();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_c2 got %b want 0", irq); end
        n_checks++; if (esc_state !== 2'd0) begin n_fail++; $display("FAIL noesc_state got %0d want 0", esc_state); end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        wr(3'd0, 32'h04);
        wr(3'd5, 32'h05);
        src[2] = 1'b1;
        repeat (5) tick();
        src[2] = 1'b0;
        repeat (10) tick();
        rd(3'd2, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL dbnc_short got %h want 0", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL dbnc_short_irq got %b want 0", irq); end
        src[2] = 1'b1;
        repeat (8) tick();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL dbnc_irq_t8 got %b want 0", irq); end
        tick();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL dbnc_irq_t9 got %b want 1", irq); end
        rd(3'd2, d);
        n_checks++; if (d !== 32'h04) begin n_fail++; $display("FAIL dbnc_status got %h want 04", d); end
        src[2] = 1'b0;
        repeat (4) tick();
        wr(3'd2, 32'h04);
        wr(3'd5, 32'h0);
        wr(3'd0, 32'h0);
    endtask

    task automatic test_edge_mode();
        logic [31:0] d;
        wr(3'd1, 32'h02);
        src[1] = 1'b1;
        repeat (5) tick();
        rd(3'd2, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL edge_set got %h want 02", d); end
        wr(3'd2, 32'h02);
        repeat (3) tick();
        rd(3'd2, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL edge_held_no_reset got %h want 0", d); end
        wr(3'd1, 32'h0);
        tick();
        rd(3'd2, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL level_set got %h want 02", d); end
        wr(3'd2, 32'h02);
        rd(3'd2, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL level_reset_after_clr got %h want 02", d); end
        src[1] = 1'b0;
        repeat (4) tick();
        wr(3'd2, 32'h02);
        rd(3'd2, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL level_cleared got %h want 0", d); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        pulse(3);
        tick();
        wr(3'd2, 32'h08);
        rd(3'd2, d);
        n_checks++; if (d !== 32'h08) begin n_fail++; $display("FAIL set_wins got %h want 08", d); end
        wr(3'd2, 32'h08);
        rd(3'd2, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL set_wins_clr got %h want 0", d); end
    endtask

    task automatic test_escalation();
        logic [31:0] d;
        wr(3'd0, 32'h01);
        wr(3'd3, 32'h8000_000A);
        rd(3'd3, d);
        n_checks++; if (d !== 32'h8000_000A) begin n_fail++; $display("FAIL esc_reg got %h want 8000000a", d); end
        pulse(0);
        repeat (3) tick();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL esc_irq got %b want 1", irq); end
        n_checks++; if (esc_state !== 2'd0) begin n_fail++; $display("FAIL esc_pre_arm got %0d want 0", esc_state); end
        tick();
        n_checks++; if (esc_state !== 2'd1) begin n_fail++; $display("FAIL esc_armed got %0d want 1", esc_state); end
        repeat (10) tick();
        n_checks++; if (esc_state !== 2'd1) begin n_fail++; $display("FAIL esc_arm10_state got %0d want 1", esc_state); end
        n_checks++; if (esc !== 1'b0) begin n_fail++; $display("FAIL esc_arm10_esc got %b want 0", esc); end
        tick();
        n_checks++; if (esc_state !== 2'd2) begin n_fail++; $display("FAIL esc_fire_state got %0d want 2", esc_state); end
        n_checks++; if (esc !== 1'b1) begin n_fail++; $display("FAIL esc_fire got %b want 1", esc); end
        wr(3'd2, 32'h01);
        repeat (3) tick();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL fire_irq_cleared got %b want 0", irq); end
        n_checks++; if (esc_state !== 2'd2 || esc !== 1'b1) begin n_fail++; $display("FAIL fire_sticky got state %0d esc %b want 2 1", esc_state, esc); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (esc !== 1'b0) begin n_fail++; $display("FAIL fire_reset_esc got %b want 0", esc); end
        n_checks++; if (esc_state !== 2'd0) begin n_fail++; $display("FAIL fire_reset_state got %0d want 0", esc_state); end
        rd(3'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL fire_reset_escreg got %h want 0", d); end
        // second run: service the alarm mid-countdown
        wr(3'd0, 32'h01);
        wr(3'd3, 32'h8000_000A);
        pulse(0);
        repeat (4) tick();
        n_checks++; if (esc_state !== 2'd1) begin n_fail++; $display("FAIL run2_armed got %0d want 1", esc_state); end
        repeat (4) tick();
        wr(3'd2, 32'h01);
        tick();
        n_checks++; if (irq !== 1'b0 || esc_state !== 2'd1) begin n_fail++; $display("FAIL run2_irq_drop got irq %b state %0d want 0 1", irq, esc_state); end
        tick();
        n_checks++; if (esc_state !== 2'd0) begin n_fail++; $display("FAIL run2_idle got %0d want 0", esc_state); end
        repeat (12) tick();
        n_checks++; if (esc !== 1'b0 || esc_state !== 2'd0) begin n_fail++; $display("FAIL run2_no_esc got esc %b state %0d want 0 0", esc, esc_state); end
        wr(3'd3, 32'h0);
        wr(3'd0, 32'h0);
    endtask

    task automatic test_lock();
        logic [31:0] d;
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'h01);
        wr(3'd0, 32'h00);
        rd(3'd0, d);
        n_checks++; if (d !== 32'h0F) begin n_fail++; $display("FAIL lock_en got %h want 0f", d); end
        wr(3'd1, 32'h05);
        rd(3'd1, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lock_mode got %h want 0", d); end
        wr(3'd5, 32'h03);
        rd(3'd5, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lock_dbnc got %h want 0", d); end
        rd(3'd4, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL lock_reg got %h want 1", d); end
        pulse(1);
        repeat (3) tick();
        rd(3'd2, d);
        n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL lock_status_set got %h want 02", d); end
        wr(3'd2, 32'h02);
        rd(3'd2, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lock_w1c got %h want 0", d); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(3'd4, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL lock_after_reset got %h want 0", d); end
        wr(3'd0, 32'h03);
        rd(3'd0, d);
        n_checks++; if (d !== 32'h03) begin n_fail++; $display("FAIL unlock_en got %h want 03", d); end
        repeat (3) tick();
        n_checks++; if (reg_rdata !== 32'h03) begin n_fail++; $display("FAIL rdata_hold got %h want 03", reg_rdata); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        src       = '0;
        reg_sel   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        test_reset();
        test_level_basic();
        test_debounce();
        test_edge_mode();
        test_same_cycle();
        test_escalation();
        test_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
